// File: rtl/usbf_dma_resp.sv
// Single-channel DMA responder: one 32-bit host word per dma_req/dma_ack; 4 clocks/word at zero-wait memory,
// stalls in MEM until mem_ack. Define USBF_DMA_RESP_TIMEOUT_EN to add a mem_ack timeout and sticky err port.
module usbf_dma_resp #(
  parameter int AW     = 15,
  parameter int LW     = 12,
  parameter int TO_MAX = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_adr,
  input  logic [LW-1:0] cfg_len,
  input  logic          cfg_dir,
  input  logic          abort,
  input  logic          dma_req,
  output logic          dma_ack,
  input  logic [31:0]   ep_rdata,
  output logic [31:0]   ep_wdata,
  output logic [AW-1:0] mem_adr,
  output logic          mem_we,
  output logic          mem_req,
  input  logic          mem_ack,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic          busy,
  output logic          done,
`ifdef USBF_DMA_RESP_TIMEOUT_EN
  output logic          err,
`endif
  output logic [LW-1:0] words_left
);

  typedef enum logic [1:0] {IDLE, MEM, ACK, GAP} state_t;

  if (TO_MAX < 1 || TO_MAX > 255) begin : g_to_max_chk
    $error("usbf_dma_resp: TO_MAX must be within 1..255");
  end

  state_t        state_q, state_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [LW-1:0] left_q, left_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          dir_q, dir_d;
  logic          req_q, req_d;
  logic          we_q, we_d;
  logic [31:0]   mwd_q, mwd_d;
  logic [31:0]   epw_q, epw_d;
  logic          cfg_ok;
`ifdef USBF_DMA_RESP_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TO_MAX - 1);
  logic [7:0]    to_cnt_q, to_cnt_d;
  logic          err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    left_d  = left_q;
    busy_d  = busy_q;
    done_d  = done_q;
    dir_d   = dir_q;
    req_d   = req_q;
    we_d    = we_q;
    mwd_d   = mwd_q;
    epw_d   = epw_q;
    cfg_ok  = 1'b0;
`ifdef USBF_DMA_RESP_TIMEOUT_EN
    to_cnt_d = to_cnt_q;
    err_d    = err_q;
`endif
    // abort discards everything in flight, including a coincident mem_ack or cfg_we
    if (abort) begin
      state_d = IDLE;
      req_d   = 1'b0;
      we_d    = 1'b0;
      busy_d  = 1'b0;
      left_d  = '0;
    end else begin
      cfg_ok = cfg_we && (state_q == IDLE || state_q == GAP);
      case (state_q)
        IDLE: begin
          if (!cfg_ok && busy_q && dma_req) begin
            state_d = MEM;
            req_d   = 1'b1;
            we_d    = !dir_q;
            if (!dir_q) mwd_d = ep_rdata;
`ifdef USBF_DMA_RESP_TIMEOUT_EN
            to_cnt_d = '0;
`endif
          end
        end
        MEM: begin
          if (mem_ack) begin
            state_d = ACK;
            req_d   = 1'b0;
            we_d    = 1'b0;
            if (dir_q) epw_d = mem_rdata;
          end
`ifdef USBF_DMA_RESP_TIMEOUT_EN
          else if (to_cnt_q == TO_LAST) begin
            state_d = IDLE;
            req_d   = 1'b0;
            we_d    = 1'b0;
            busy_d  = 1'b0;
            err_d   = 1'b1;
          end else begin
            to_cnt_d = to_cnt_q + 8'd1;
          end
`endif
        end
        ACK: begin
          state_d = GAP;
          adr_d   = adr_q + AW'(1);
          if (left_q != '0) left_d = left_q - LW'(1);
          if (left_q == LW'(1)) begin
            busy_d = 1'b0;
            done_d = 1'b1;
          end
        end
        GAP:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
      if (cfg_ok) begin
        left_d = cfg_len;
        adr_d  = cfg_adr;
        dir_d  = cfg_dir;
        done_d = 1'b0;
        busy_d = (cfg_len != '0);
`ifdef USBF_DMA_RESP_TIMEOUT_EN
        err_d  = 1'b0;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      adr_q   <= '0;
      left_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dir_q   <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      mwd_q   <= '0;
      epw_q   <= '0;
`ifdef USBF_DMA_RESP_TIMEOUT_EN
      to_cnt_q <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      left_q  <= left_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dir_q   <= dir_d;
      req_q   <= req_d;
      we_q    <= we_d;
      mwd_q   <= mwd_d;
      epw_q   <= epw_d;
`ifdef USBF_DMA_RESP_TIMEOUT_EN
      to_cnt_q <= to_cnt_d;
      err_q    <= err_d;
`endif
    end
  end

  assign dma_ack    = (state_q == ACK);
  assign mem_req    = req_q;
  assign mem_we     = we_q;
  assign mem_adr    = adr_q;
  assign mem_wdata  = mwd_q;
  assign ep_wdata   = epw_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign words_left = left_q;
`ifdef USBF_DMA_RESP_TIMEOUT_EN
  assign err        = err_q;
`endif

endmodule

// File: tb/tb_usbf_dma_resp.sv
// Directed bench for usbf_dma_resp: transaction-level model checked every cycle plus hand-computed expectations.
module tb_usbf_dma_resp;
  localparam int AW = 15;
  localparam int LW = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cfg_we = 1'b0, cfg_dir = 1'b0, abort = 1'b0, dma_req = 1'b0, mem_ack = 1'b0;
  logic [AW-1:0] cfg_adr = '0;
  logic [LW-1:0] cfg_len = '0;
  logic [31:0]   ep_rdata = '0, mem_rdata = '0;
  logic          dma_ack, mem_we, mem_req, busy, done;
  logic [31:0]   ep_wdata, mem_wdata;
  logic [AW-1:0] mem_adr;
  logic [LW-1:0] words_left;

  usbf_dma_resp dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_adr(cfg_adr), .cfg_len(cfg_len),
    .cfg_dir(cfg_dir), .abort(abort), .dma_req(dma_req), .dma_ack(dma_ack),
    .ep_rdata(ep_rdata), .ep_wdata(ep_wdata), .mem_adr(mem_adr), .mem_we(mem_we),
    .mem_req(mem_req), .mem_ack(mem_ack), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .words_left(words_left)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // transaction-level model: a word is "outstanding" until mem_ack, then acked, then a cooldown cycle
  typedef struct packed {
    logic          busy, done, dir, req, we, ack, gap;
    logic [LW-1:0] left;
    logic [AW-1:0] adr;
    logic [31:0]   epw, mw;
  } model_t;
  model_t m = '0;

  function automatic model_t model_next(model_t c);
    model_t n = c;
    if (!rst) return '0;
    if (abort) begin
      n.req = 0; n.we = 0; n.ack = 0; n.gap = 0; n.busy = 0; n.left = '0;
      return n;
    end
    if (c.ack) begin
      n.ack = 0; n.gap = 1; n.adr = c.adr + AW'(1); n.left = c.left - LW'(1);
      if (c.left == LW'(1)) begin n.busy = 0; n.done = 1; end
      return n;
    end
    if (c.req) begin
      if (mem_ack) begin
        n.req = 0; n.we = 0; n.ack = 1;
        if (c.dir) n.epw = mem_rdata;
      end
      return n;
    end
    n.gap = 0;
    if (cfg_we) begin
      n.left = cfg_len; n.adr = cfg_adr; n.dir = cfg_dir; n.done = 0; n.busy = (cfg_len != '0);
    end else if (!c.gap && c.busy && dma_req) begin
      n.req = 1; n.we = !c.dir;
      if (!c.dir) n.mw = ep_rdata;
    end
    return n;
  endfunction

  always @(posedge clk) m <= model_next(m);

  // host memory responder with logging of every acknowledged access
  int            ack_delay = 0;
  bit            ack_block = 0, ack_force = 0;
  int            wait_cnt = 0;
  logic [AW-1:0] acc_adr[$];
  logic          acc_we[$];
  logic [31:0]   acc_wd[$];
  int            memack_q[$];

  always @(negedge clk) begin
    if (mem_req && (ack_force || (!ack_block && wait_cnt >= ack_delay))) begin
      mem_ack   <= 1'b1;
      mem_rdata <= 32'hC0DE_0000 | 32'(mem_adr);
      wait_cnt  <= 0;
      acc_adr.push_back(mem_adr);
      acc_we.push_back(mem_we);
      acc_wd.push_back(mem_wdata);
      memack_q.push_back(cyc);
    end else begin
      mem_ack  <= 1'b0;
      wait_cnt <= mem_req ? wait_cnt + 1 : 0;
    end
  end

  int            ack_q[$];
  logic [LW-1:0] wl_q[$];
  logic          prev_ack = 1'b0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic compare();
    chk("dma_ack", 64'(dma_ack), 64'(m.ack));
    chk("mem_req", 64'(mem_req), 64'(m.req));
    chk("mem_we", 64'(mem_we), 64'(m.we));
    chk("mem_adr", 64'(mem_adr), 64'(m.adr));
    chk("mem_wdata", 64'(mem_wdata), 64'(m.mw));
    chk("ep_wdata", 64'(ep_wdata), 64'(m.epw));
    chk("busy", 64'(busy), 64'(m.busy));
    chk("done", 64'(done), 64'(m.done));
    chk("words_left", 64'(words_left), 64'(m.left));
    chk("ack_single_pulse", 64'(dma_ack && prev_ack), 64'd0);
    if (dma_ack) ack_q.push_back(cyc);
    if (prev_ack) wl_q.push_back(words_left);
    prev_ack = dma_ack;
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic arm(logic [AW-1:0] a, logic [LW-1:0] l, logic d);
    cfg_adr = a; cfg_len = l; cfg_dir = d; cfg_we = 1'b1;
    tick(1);
    cfg_we = 1'b0;
  endtask

  task automatic wait_acks(int n, int budget);
    int k = 0;
    while (ack_q.size() < n && k < budget) begin
      tick(1);
      k++;
    end
    chk("ack_count", 64'(ack_q.size()), 64'(n));
  endtask

  task automatic clear_logs();
    ack_q.delete(); wl_q.delete(); acc_adr.delete(); acc_we.delete(); acc_wd.delete(); memack_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (cyc >= 1) compare();
      end
    join_none

    // reset state
    tick(2);
    chk("rst_dma_ack", 64'(dma_ack), 64'd0);
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_words_left", 64'(words_left), 64'd0);
    chk("rst_mem_adr", 64'(mem_adr), 64'd0);
    chk("rst_ep_wdata", 64'(ep_wdata), 64'd0);
    chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    rst = 1'b1;
    tick(2);

    // IN, 3 words, zero-wait memory, request held high
    clear_logs();
    dma_req = 1'b1;
    arm(15'h10, 12'd3, 1'b1);
    wait_acks(3, 40);
    dma_req = 1'b0;
    tick(3);
    chk("t1_nacc", 64'(acc_adr.size()), 64'd3);
    chk("t1_adr0", 64'(acc_adr[0]), 64'h10);
    chk("t1_adr1", 64'(acc_adr[1]), 64'h11);
    chk("t1_adr2", 64'(acc_adr[2]), 64'h12);
    chk("t1_ack_gap01", 64'(ack_q[1] - ack_q[0]), 64'd4);
    chk("t1_ack_gap12", 64'(ack_q[2] - ack_q[1]), 64'd4);
    chk("t1_ep_wdata", 64'(ep_wdata), 64'hC0DE_0012);
    chk("t1_wl0", 64'(wl_q[0]), 64'd2);
    chk("t1_wl2", 64'(wl_q[2]), 64'd0);
    chk("t1_done", 64'(done), 64'd1);
    chk("t1_busy", 64'(busy), 64'd0);
    chk("t1_mem_adr", 64'(mem_adr), 64'h13);

    // OUT, 2 words, mem_ack delayed 3 cycles
    clear_logs();
    ack_delay = 3;
    ep_rdata  = 32'hA5A5_0001;
    dma_req   = 1'b1;
    arm(15'h40, 12'd2, 1'b0);
    wait_acks(1, 40);
    ep_rdata = 32'hA5A5_0002;
    wait_acks(2, 40);
    dma_req = 1'b0;
    tick(3);
    chk("t2_we0", 64'(acc_we[0]), 64'd1);
    chk("t2_we1", 64'(acc_we[1]), 64'd1);
    chk("t2_wd0", 64'(acc_wd[0]), 64'hA5A5_0001);
    chk("t2_wd1", 64'(acc_wd[1]), 64'hA5A5_0002);
    chk("t2_adr1", 64'(acc_adr[1]), 64'h41);
    chk("t2_ack_after_memack", 64'(ack_q[0] - memack_q[0]), 64'd1);
    chk("t2_wl0", 64'(wl_q[0]), 64'd1);
    chk("t2_wl1", 64'(wl_q[1]), 64'd0);
    chk("t2_done", 64'(done), 64'd1);

    // request dropped during the cooldown cycle after the first of 4 words
    clear_logs();
    ack_delay = 0;
    dma_req   = 1'b1;
    arm(15'h100, 12'd4, 1'b1);
    wait_acks(1, 20);
    dma_req = 1'b0;
    tick(8);
    chk("t3_nacc_paused", 64'(acc_adr.size()), 64'd1);
    chk("t3_busy_paused", 64'(busy), 64'd1);
    chk("t3_wl_paused", 64'(words_left), 64'd3);
    chk("t3_mem_req_paused", 64'(mem_req), 64'd0);
    dma_req = 1'b1;
    wait_acks(4, 40);
    dma_req = 1'b0;
    tick(3);
    chk("t3_adr3", 64'(acc_adr[3]), 64'h103);
    chk("t3_done", 64'(done), 64'd1);
    chk("t3_wl_end", 64'(words_left), 64'd0);

    // address wrap at the top of the host space
    clear_logs();
    dma_req = 1'b1;
    arm(15'h7FFF, 12'd2, 1'b1);
    wait_acks(2, 30);
    dma_req = 1'b0;
    tick(3);
    chk("t4_adr0", 64'(acc_adr[0]), 64'h7FFF);
    chk("t4_adr1", 64'(acc_adr[1]), 64'h0);
    chk("t4_mem_adr", 64'(mem_adr), 64'h1);
    chk("t4_ep_wdata", 64'(ep_wdata), 64'hC0DE_0000);
    chk("t4_done", 64'(done), 64'd1);

    // zero length arms nothing but clears done
    clear_logs();
    arm(15'h300, 12'd0, 1'b1);
    dma_req = 1'b1;
    tick(6);
    chk("t5_len0_done", 64'(done), 64'd0);
    chk("t5_len0_busy", 64'(busy), 64'd0);
    chk("t5_len0_noack", 64'(ack_q.size()), 64'd0);

    // abort mid-MEM with a coincident mem_ack
    ack_block = 1'b1;
    ep_rdata  = 32'h1234_5678;
    arm(15'h200, 12'd3, 1'b0);
    begin
      int k = 0;
      while (!mem_req && k < 10) begin tick(1); k++; end
    end
    chk("t5_mem_req_seen", 64'(mem_req), 64'd1);
    tick(2);
    ack_force = 1'b1;
    abort     = 1'b1;
    tick(1);
    abort     = 1'b0;
    ack_force = 1'b0;
    tick(5);
    chk("t5_abort_noack", 64'(ack_q.size()), 64'd0);
    chk("t5_abort_busy", 64'(busy), 64'd0);
    chk("t5_abort_wl", 64'(words_left), 64'd0);
    chk("t5_abort_done", 64'(done), 64'd0);
    chk("t5_abort_mem_req", 64'(mem_req), 64'd0);

    // abort beats a simultaneous cfg_we
    cfg_len = 12'd5; cfg_adr = 15'h500; cfg_dir = 1'b1; cfg_we = 1'b1; abort = 1'b1;
    tick(1);
    cfg_we = 1'b0; abort = 1'b0;
    tick(3);
    chk("t5_abort_cfg_busy", 64'(busy), 64'd0);
    chk("t5_abort_cfg_wl", 64'(words_left), 64'd0);

    // re-arm after abort
    ack_block = 1'b0;
    arm(15'h300, 12'd1, 1'b1);
    wait_acks(1, 20);
    dma_req = 1'b0;
    tick(3);
    chk("t5_rearm_adr", 64'(acc_adr[acc_adr.size()-1]), 64'h300);
    chk("t5_rearm_ep_wdata", 64'(ep_wdata), 64'hC0DE_0300);
    chk("t5_rearm_done", 64'(done), 64'd1);
    chk("t5_rearm_wl", 64'(words_left), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
